// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters, resolution and stats
module branch_predictor #(
  parameter int         PC_W     = 9,
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  output logic [31:0]     pred_target,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic            ex_taken,
  input  logic [31:0]     ex_target,
  input  logic            ex_pred_taken,
  input  logic [31:0]     ex_pred_target,
  output logic            mispredict,
  output logic [31:0]     redirect_pc,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic             tbl_valid  [ENTRIES];
  logic [TAG_W-1:0] tbl_tag    [ENTRIES];
  logic             tbl_jump   [ENTRIES];
  logic [1:0]       tbl_cnt    [ENTRIES];
  logic [31:0]      tbl_target [ENTRIES];

  logic [31:0] br_cnt;
  logic [31:0] mp_cnt;

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             resolve;
  logic             alias_hit;
  logic [31:0]      if_pc_ext;
  logic [31:0]      ex_pc_ext;

  assign if_idx    = if_pc[IDX_W+1:2];
  assign if_tag    = if_pc[PC_W-1:IDX_W+2];
  assign ex_idx    = ex_pc[IDX_W+1:2];
  assign ex_tag    = ex_pc[PC_W-1:IDX_W+2];
  assign if_pc_ext = {{(32-PC_W){1'b0}}, if_pc};
  assign ex_pc_ext = {{(32-PC_W){1'b0}}, ex_pc};

  // Lookup reads the registered table only, so a same-cycle update is not bypassed.
  assign if_hit      = tbl_valid[if_idx] && (tbl_tag[if_idx] == if_tag);
  assign pred_taken  = if_hit && (tbl_jump[if_idx] || tbl_cnt[if_idx][1]);
  assign pred_target = pred_taken ? tbl_target[if_idx] : (if_pc_ext + 32'd4);

  assign ex_hit    = tbl_valid[ex_idx] && (tbl_tag[ex_idx] == ex_tag);
  assign resolve   = ex_valid && (ex_is_branch || ex_is_jump);
  // A non-control instruction predicted taken means the BTB entry aliased onto it.
  assign alias_hit = ex_valid && !ex_is_branch && !ex_is_jump && ex_pred_taken;

  assign mispredict = (resolve && ((ex_taken != ex_pred_taken) ||
                                   (ex_taken && (ex_target != ex_pred_target)))) ||
                      alias_hit;
  assign redirect_pc = (ex_taken && !alias_hit) ? ex_target : (ex_pc_ext + 32'd4);

  assign stat_branches    = br_cnt;
  assign stat_mispredicts = mp_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_valid[i]  <= 1'b0;
        tbl_tag[i]    <= '0;
        tbl_jump[i]   <= 1'b0;
        tbl_cnt[i]    <= CNT_INIT;
        tbl_target[i] <= '0;
      end
    end else if (resolve) begin
      if (ex_hit) begin
        if (ex_is_jump)
          tbl_cnt[ex_idx] <= 2'b11;
        else if (ex_taken)
          tbl_cnt[ex_idx] <= (tbl_cnt[ex_idx] == 2'b11) ? 2'b11 : tbl_cnt[ex_idx] + 2'd1;
        else
          tbl_cnt[ex_idx] <= (tbl_cnt[ex_idx] == 2'b00) ? 2'b00 : tbl_cnt[ex_idx] - 2'd1;
        if (ex_taken)
          tbl_target[ex_idx] <= ex_target;
        tbl_jump[ex_idx] <= ex_is_jump;
      end else if (ex_taken) begin
        tbl_valid[ex_idx]  <= 1'b1;
        tbl_tag[ex_idx]    <= ex_tag;
        tbl_jump[ex_idx]   <= ex_is_jump;
        tbl_cnt[ex_idx]    <= ex_is_jump ? 2'b11 : 2'b10;
        tbl_target[ex_idx] <= ex_target;
      end
    end else if (alias_hit) begin
      tbl_valid[ex_idx] <= 1'b0;
    end
  end

  // Performance counters saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else begin
      if (resolve && (br_cnt != 32'hFFFF_FFFF))
        br_cnt <= br_cnt + 32'd1;
      if (mispredict && (mp_cnt != 32'hFFFF_FFFF))
        mp_cnt <= mp_cnt + 32'd1;
    end
  end

endmodule
